// File: rtl/core_pkg.sv
// Shared definitions for the RV32 5-stage pipeline registers.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'h9;

  // Control bundle carried down ID/EX, EX/MEM and MEM/WB.
  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and PC / IF_ID stall generation.
module hazard_detect (
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_flush,
  input  logic       mem_busy,
  output logic       load_use,
  output logic       pc_write,
  output logic       if_id_write
);

  logic stall;

  // A load in EX whose destination is read by ID forces one bubble; a flush
  // or memory freeze overrides the stall request.
  always_comb begin
    load_use = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                (id_uses_rs2 & (id_rs2 == ex_rd)));
    stall       = load_use & ~ex_flush & ~mem_busy & ~reset;
    pc_write    = ~stall;
    if_id_write = ~stall;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory hold
// and a saturating bubble counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               id_alusrc,
  input  logic               id_branch,
  input  logic               id_jump,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               ex_flush,
  input  logic               mem_busy,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_alusrc,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               pc_write,
  output logic               if_id_write,
  output logic [CNT_W-1:0]   bubble_count
);

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rs1_p1;
  logic [4:0]      rs2_p1;
  logic [4:0]      rd_p1;
  ctrl_t           ctrl_p1;
  ctrl_t           id_ctrl;
  logic [CNT_W-1:0] bubble_cnt;
  logic            load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Gather the decoded control into the shared bundle.
  always_comb begin
    id_ctrl          = '0;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.memread  = id_memread;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.branch   = id_branch;
    id_ctrl.jump     = id_jump;
    id_ctrl.aluop    = id_aluop;
  end

  hazard_detect u_hazard (
    .reset       (reset),
    .ex_valid    (vld_p1),
    .ex_memread  (ctrl_p1.memread),
    .ex_rd       (rd_p1),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_flush    (ex_flush),
    .mem_busy    (mem_busy),
    .load_use    (load_use),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // ID -> EX boundary: hold on mem_busy, bubble on flush or load-use,
  // otherwise capture ID; the counter tracks load-use bubbles only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      ctrl_p1     <= '0;
      bubble_cnt  <= '0;
    end else if (!mem_busy) begin
      if (ex_flush || load_use) begin
        vld_p1      <= 1'b0;
        pc_p1       <= '0;
        rs1_data_p1 <= '0;
        rs2_data_p1 <= '0;
        imm_p1      <= '0;
        rs1_p1      <= '0;
        rs2_p1      <= '0;
        rd_p1       <= '0;
        ctrl_p1     <= '0;
        if (!ex_flush) bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        vld_p1      <= id_valid;
        pc_p1       <= id_pc;
        rs1_data_p1 <= id_rs1_data;
        rs2_data_p1 <= id_rs2_data;
        imm_p1      <= id_imm;
        rs1_p1      <= id_rs1;
        rs2_p1      <= id_rs2;
        rd_p1       <= id_rd;
        ctrl_p1     <= id_valid ? id_ctrl : '0;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_pc        = pc_p1;
  assign ex_rs1_data  = rs1_data_p1;
  assign ex_rs2_data  = rs2_data_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs1       = rs1_p1;
  assign ex_rs2       = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_regwrite  = ctrl_p1.regwrite;
  assign ex_memread   = ctrl_p1.memread;
  assign ex_memwrite  = ctrl_p1.memwrite;
  assign ex_memtoreg  = ctrl_p1.memtoreg;
  assign ex_alusrc    = ctrl_p1.alusrc;
  assign ex_branch    = ctrl_p1.branch;
  assign ex_jump      = ctrl_p1.jump;
  assign ex_aluop     = ctrl_p1.aluop;
  assign bubble_count = bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32 5-stage core, with load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX, including the rs1/rs2/rd fields consumed by the forwarding logic.
- Inserts one bubble on a load-use dependency and stalls PC/IF_ID for that cycle.
- Applies branch/jump flush from EX and a global memory-stall hold; counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width (pc, operands, immediate).
- ALUOP_W, 4, width of the ALU operation code.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register specifiers.
- id_uses_rs1, id_uses_rs2  in  1  the instruction actually reads rs1/rs2.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch, id_jump  in  1  decoded control.
- id_aluop  in  ALUOP_W  ALU operation.
- ex_flush  in  1  taken branch/jump resolved in EX; kill ID instruction.
- mem_busy  in  1  data memory stall; freeze the whole pipeline.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered specifiers (to forwarding logic).
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_jump  out  1  registered control.
- ex_aluop  out  ALUOP_W  registered ALU op.
- pc_write  out  1  0 = hold PC.
- if_id_write  out  1  0 = hold IF/ID register.
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, immediate): all ex_* outputs 0, ex_valid 0, bubble_count 0. pc_write and if_id_write are combinational and evaluate to 1 once reset deasserts; they are forced to 1 while reset is high.
- load_use (combinational) = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Per-edge update priority (highest first):
  - (1) mem_busy=1: all registers hold, bubble_count holds.
  - (2) ex_flush=1: load bubble. ex_valid=0; regwrite, memread, memwrite, branch, jump cleared. Data and specifier fields are don't-care but must be loaded as 0.
  - (3) load_use=1: insert bubble, identical to (2); bubble_count += 1, saturating at all-ones.
  - (4) otherwise: capture all id_* fields; ex_valid = id_valid. If id_valid=0, control bits are loaded as 0.
- pc_write = if_id_write = ~(load_use & ~ex_flush & ~mem_busy). The stall lasts exactly one cycle: after the bubble, ex_memread=0, so load_use drops.
- Flush and load_use in the same cycle: flush wins, no stall, counter unchanged.
- mem_busy: stall outputs stay 1. The external PC and IF/ID logic also freeze on mem_busy. A flush presented during mem_busy is ignored; EX re-asserts it once mem_busy drops, because the branch is still in EX.
- rd=x0 loads never cause a stall. A store using the loaded register as rs2 does stall (no MEM-to-MEM forwarding).
- Latency: one cycle ID to EX. No combinational path from id_* to ex_* outputs.
- Reset asserted mid-stall: outputs clear immediately. The stall releases because ex_valid=0.

Decomposition:
- Shared package (core_pkg): XLEN, ALUOP_W, ALU opcode constants, and a ctrl bundle typedef (regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop) so the ID/EX, EX/MEM and MEM/WB registers share one definition.
- One natural sub-module: hazard_detect (the pure combinational load_use, pc_write and if_id_write logic), instantiated inside id_ex_stage. The pipeline register and counter stay in the top.

Test Plan:
- Reset mid-run: load ex_rd=5, ex_regwrite=1, then pulse reset -> all ex_* =0 immediately, bubble_count=0, pc_write=1.
- Load-use: EX holds lw x5 (memread=1, rd=5); ID holds add x6,x5,x7 (uses_rs1, rs1=5) -> pc_write=if_id_write=0 for exactly 1 cycle; next cycle ex_valid=0, all control 0; cycle after, ex_rs1=5, ex_rd=6; bubble_count=1.
- No false stall: lw x0 followed by ID rs1=0; and lw x5 followed by an instruction with uses_rs2=0, rs2=5 -> no stall, bubble_count unchanged.
- Flush vs load-use: load_use true and ex_flush=1 in the same cycle -> pc_write=1, bubble loaded, bubble_count unchanged.
- mem_busy hold: mem_busy=1 for 3 cycles while id_* changes and ex_flush pulses -> ex_* stable all 3 cycles; after release, the next id_* is captured normally.
- Counter saturation: with CNT_W=4, 17 load-use events -> bubble_count stops at 15.
